up_counter_ctl: RTL and testbench

- Controlled 8-bit up counter: counts from 0, or from a loaded value, up to a programmable limit.
- Either wraps to 0 at the limit or stops there, and flags each terminal count.
- Up-direction companion to the team's free-running down counter; serves as the tick and sequence source for timers and test sequencing.
- Single clock domain.

---
 rtl/up_counter_ctl_if.sv | 13 +
 rtl/up_counter_ctl.sv | 51 +++++
 tb/tb_up_counter_ctl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/up_counter_ctl_if.sv
// up_counter_ctl_if: control/status bundle for up_counter_ctl; UPCNT_WRAPCNT_EN adds the wraps count.
interface up_counter_ctl_if #(parameter int WIDTH = 8);
  logic en, load, mode, tc, busy, done;
  logic [WIDTH-1:0] load_val, limit, data;
`ifdef UPCNT_WRAPCNT_EN
  logic [7:0] wraps;
  modport master (output en, load, load_val, limit, mode, input data, tc, busy, done, wraps);
  modport slave (input en, load, load_val, limit, mode, output data, tc, busy, done, wraps);
`else
  modport master (output en, load, load_val, limit, mode, input data, tc, busy, done);
  modport slave (input en, load, load_val, limit, mode, output data, tc, busy, done);
`endif
endinterface

// File: rtl/up_counter_ctl.sv
// up_counter_ctl: loadable up counter to a captured limit, wrap or one-shot, with terminal-count pulse.
// Define UPCNT_WRAPCNT_EN to add the saturating wraps count of terminal-count events.
module up_counter_ctl #(parameter int WIDTH = 8) (
  input logic clock,
  input logic start,
  up_counter_ctl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] limit_q;
  logic mode_q, hit;
  assign hit = state == RUN && bus.en && bus.data == limit_q;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  always_ff @(posedge clock or posedge start)
    if (start) begin
      state <= IDLE;
      bus.data <= '0;
      bus.tc <= 1'b0;
      limit_q <= '0;
      mode_q <= 1'b0;
`ifdef UPCNT_WRAPCNT_EN
      bus.wraps <= '0;
`endif
    end else if (bus.load) begin
      bus.data <= bus.load_val;
      bus.tc <= 1'b0;
      state <= state == DONE ? IDLE : state;
`ifdef UPCNT_WRAPCNT_EN
      bus.wraps <= '0;
`endif
    end else begin
      bus.tc <= hit;
`ifdef UPCNT_WRAPCNT_EN
      if (hit && bus.wraps != 8'hff) bus.wraps <= bus.wraps + 8'd1;
`endif
      case (state)
        IDLE: if (bus.en) begin
          limit_q <= bus.limit;
          mode_q <= bus.mode;
          state <= RUN;
        end
        RUN: if (bus.en) begin
          if (bus.data != limit_q) bus.data <= bus.data + WIDTH'(1);
          else if (mode_q) state <= DONE;
          else bus.data <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_up_counter_ctl.sv
// tb_up_counter_ctl: directed and random stimulus checked against a behavioural counter model.
module tb_up_counter_ctl;
  logic clock = 1'b0;
  logic start = 1'b1;
  int total = 0, bad = 0;
  int m_data, m_lim, m_wraps;
  bit m_mode, m_run, m_done, m_tc;
  int wrap_d[5] = '{1, 2, 3, 0, 1};
  int wrap_t[5] = '{0, 0, 0, 1, 0};
  int pause_en[5] = '{1, 1, 0, 0, 1};
  int pause_d[5] = '{1, 2, 2, 2, 3};
  up_counter_ctl_if #(.WIDTH(8)) u_if ();
  up_counter_ctl #(.WIDTH(8)) dut (.clock(clock), .start(start), .bus(u_if.slave));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_data = 0; m_lim = 0; m_mode = 0; m_run = 0; m_done = 0; m_tc = 0; m_wraps = 0;
  endtask
  task automatic model_step();
    if (u_if.load) begin
      m_data = u_if.load_val; m_tc = 0; m_done = 0; m_wraps = 0;
    end else if (m_run) begin
      m_tc = 0;
      if (u_if.en) begin
        if (m_data != m_lim) m_data = (m_data + 1) % 256;
        else begin
          m_tc = 1;
          m_wraps = m_wraps < 255 ? m_wraps + 1 : 255;
          if (m_mode) begin m_run = 0; m_done = 1; end
          else m_data = 0;
        end
      end
    end else begin
      m_tc = 0;
      if (!m_done && u_if.en) begin m_lim = u_if.limit; m_mode = u_if.mode; m_run = 1; end
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".data"}, u_if.data, m_data);
    chk({tag, ".tc"}, u_if.tc, m_tc);
    chk({tag, ".busy"}, u_if.busy, m_run);
    chk({tag, ".done"}, u_if.done, m_done);
`ifdef UPCNT_WRAPCNT_EN
    chk({tag, ".wraps"}, u_if.wraps, m_wraps);
`endif
  endtask
  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1 check_all(tag);
  endtask
  task automatic do_reset(input string tag);
    start = 1'b1;
    #1 model_reset();
    check_all(tag);
    start = 1'b0;
    #1;
  endtask
  initial begin
    u_if.en = 0; u_if.load = 0; u_if.load_val = 0; u_if.limit = 0; u_if.mode = 0;
    model_reset();
    #22 check_all("reset");
    start = 1'b0;
    repeat (3) step("idle");
    u_if.limit = 3; u_if.mode = 0; u_if.en = 1;
    step("wrap_entry");
    for (int i = 0; i < 5; i++) begin
      step("wrap");
      chk("wrap_seq", u_if.data, wrap_d[i]);
      chk("wrap_tc", u_if.tc, wrap_t[i]);
      chk("wrap_busy", u_if.busy, 1);
    end
    do_reset("rst1");
    u_if.limit = 5; u_if.mode = 1; u_if.en = 1;
    step("os_entry");
    for (int i = 1; i <= 5; i++) begin
      step("os_count");
      chk("os_seq", u_if.data, i);
    end
    step("os_end");
    chk("os_tc", u_if.tc, 1);
    chk("os_done", u_if.done, 1);
    chk("os_busy", u_if.busy, 0);
    repeat (10) begin
      step("os_hold");
      chk("os_hold_data", u_if.data, 5);
    end
    u_if.load = 1; u_if.load_val = 0;
    step("os_load");
    chk("os_load_done", u_if.done, 0);
    u_if.load = 0; u_if.en = 0;
    step("os_idle");
    chk("os_idle_busy", u_if.busy, 0);
    u_if.limit = 2; u_if.mode = 0; u_if.en = 1;
    step("ld_entry");
    u_if.load = 1; u_if.load_val = 250;
    step("ld_edge");
    chk("ld_val", u_if.data, 250);
    u_if.load = 0;
    for (int i = 0; i < 8; i++) begin
      step("ld_run");
      chk("ld_seq", u_if.data, (251 + i) % 256);
      chk("ld_tc_low", u_if.tc, 0);
    end
    step("ld_tc");
    chk("ld_tc_fire", u_if.tc, 1);
    chk("ld_tc_data", u_if.data, 0);
    do_reset("rst2");
    u_if.limit = 9; u_if.mode = 0; u_if.en = 1;
    step("pause_entry");
    for (int i = 0; i < 5; i++) begin
      u_if.en = pause_en[i][0];
      step("pause");
      chk("pause_seq", u_if.data, pause_d[i]);
    end
    #3 start = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    chk("async_data", u_if.data, 0);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset("rand_rst");
      u_if.en = $urandom_range(0, 3) != 0;
      u_if.load = $urandom_range(0, 9) == 0;
      u_if.load_val = 8'($urandom);
      u_if.limit = 8'($urandom_range(0, 15));
      u_if.mode = 1'($urandom);
      step("rand");
    end
    u_if.load = 0;
`ifdef UPCNT_WRAPCNT_EN
    do_reset("rst3");
    u_if.limit = 0; u_if.mode = 0; u_if.en = 1;
    step("wc_entry");
    repeat (300) step("wc_run");
    chk("wc_sat", u_if.wraps, 255);
    u_if.load = 1; u_if.load_val = 0;
    step("wc_load");
    chk("wc_clear", u_if.wraps, 0);
    u_if.load = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
